// File: rtl/h_initiator.sv
// Hash-table initiator: registers client commands into requests, tracks them with credits and
// returns their responses to the client in issue order. Optional statistics: H_INITIATOR_STATS_EN.
// Latency: cmd -> req 1 cycle, rsp_vld -> out_vld 1 cycle. Backpressure: cmd_rdy drops on a full stage, no credit or a CLEAR drain.

package cfg_pkg;
  localparam int K_W = 16;
  localparam int V_W = 32;
endpackage

// Generic synchronous FIFO; the extra pointer bit separates full from empty.
// Latency: a pushed entry is at the head one cycle later, with no fall-through.
// Backpressure: a push while full or a pop while empty is ignored; callers avoid both.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Advance the pointers; they wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_vld && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)     rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: it is only read behind a non-empty flag.
  always_ff @(posedge clk) begin
    if (push_vld && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// Hash-table initiator: single command stage, credit counter, in-flight tag FIFO and response FIFO.
// Latency: cmd -> req 1 cycle, rsp_vld -> out_vld 1 cycle.
// Backpressure: cmd_rdy low on a full stage, with credits exhausted, or while a CLEAR drains/completes.
module h_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int K_W             = cfg_pkg::K_W,
  parameter int V_W             = cfg_pkg::V_W
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  logic [2:0]     cmd_opcode,
  input  logic [K_W-1:0] cmd_key,
  input  logic [V_W-1:0] cmd_value,
  output logic           req_vld,
  input  logic           req_rdy,
  output logic [2:0]     req_opcode,
  output logic [K_W-1:0] req_key,
  output logic [V_W-1:0] req_value,
  input  logic           rsp_vld,
  input  logic [2:0]     rsp_status,
  input  logic [V_W-1:0] rsp_value,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [2:0]     out_opcode,
  output logic [2:0]     out_status,
  output logic [V_W-1:0] out_value,
  output logic           busy,
  output logic           err
`ifdef H_INITIATOR_STATS_EN
  ,
  output logic [31:0]    stat_hit,
  output logic [31:0]    stat_miss,
  output logic [31:0]    stat_issue
`endif
);
  localparam logic [2:0] OP_INSERT    = 3'b000;
  localparam logic [2:0] OP_FIND      = 3'b100;
  localparam logic [2:0] OP_CLEAR     = 3'b111;
  localparam logic [2:0] ST_SUCCESS   = 3'b000;
  localparam logic [2:0] ST_NOTFOUND  = 3'b111;

  localparam logic [1:0] S_IDLE       = 2'b00;
  localparam logic [1:0] S_DRAIN      = 2'b01;
  localparam logic [1:0] S_CLEAR_WAIT = 2'b10;

  localparam int             CW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0]  MAX_C = CW'(MAX_OUTSTANDING);
  localparam int             RW    = 6 + V_W;

  logic [1:0]     state_q;
  logic           run_q;
  logic           st_vld_q;
  logic [2:0]     st_op_q;
  logic [K_W-1:0] st_key_q;
  logic [V_W-1:0] st_val_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  lcl_cnt_q;
  logic           err_q;

  logic           st_known, credit_ok, drain_hold;
  logic           req_fire, lcl_issue, st_adv, cmd_fire;
  logic           tag_empty, tag_full, head_lcl, rsp_ok, rsp_drop, lcl_done, tag_pop;
  logic [3:0]     tag_head;
  logic           rf_empty, rf_full, out_fire, clear_done;
  logic [RW-1:0]  rf_din, rf_head;

  // Unknown opcodes never reach the table; they are answered locally but still hold a credit
  // and a tag slot so their response stays in issue order.
  assign st_known   = (st_op_q == OP_INSERT) || (st_op_q == OP_FIND) || (st_op_q == OP_CLEAR);
  assign credit_ok  = (cnt_q != MAX_C) && !tag_full;
  assign drain_hold = (state_q == S_DRAIN) && !tag_empty;
  // Real requests wait behind any local tag, so a table response never lands on a local head.
  assign req_vld    = st_vld_q && st_known && credit_ok && !drain_hold && (lcl_cnt_q == '0);
  assign req_fire   = req_vld && req_rdy;
  assign lcl_issue  = st_vld_q && !st_known && credit_ok;
  assign st_adv     = req_fire || lcl_issue;
  assign cmd_rdy    = run_q && (state_q == S_IDLE) && (!st_vld_q || st_adv);
  assign cmd_fire   = cmd_vld && cmd_rdy;

  assign req_opcode = st_op_q;
  assign req_key    = st_key_q;
  assign req_value  = st_val_q;

  fifo #(.W(4), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .push_vld (st_adv),
    .push_dat ({lcl_issue, st_op_q}),
    .pop      (tag_pop),
    .head_dat (tag_head),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  assign head_lcl   = !tag_empty && tag_head[3];
  assign rsp_drop   = tag_empty || tag_head[3] || rf_full;
  assign rsp_ok     = rsp_vld && !rsp_drop;
  assign lcl_done   = head_lcl && !rsp_vld && !rf_full;
  assign tag_pop    = rsp_ok || lcl_done;
  assign clear_done = rsp_ok && (tag_head[2:0] == OP_CLEAR);
  assign rf_din     = rsp_ok ? {tag_head[2:0], rsp_status, rsp_value}
                             : {tag_head[2:0], ST_NOTFOUND, {V_W{1'b0}}};

  fifo #(.W(RW), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
    .clk      (clk),
    .arst_n   (arst_n),
    .push_vld (tag_pop),
    .push_dat (rf_din),
    .pop      (out_fire),
    .head_dat (rf_head),
    .empty    (rf_empty),
    .full     (rf_full)
  );

  assign out_vld    = !rf_empty;
  assign out_fire   = out_vld && out_rdy;
  assign out_opcode = out_vld ? rf_head[RW-1 -: 3]  : 3'b000;
  assign out_status = out_vld ? rf_head[V_W+2 -: 3] : 3'b000;
  assign out_value  = out_vld ? rf_head[V_W-1:0]    : {V_W{1'b0}};

  assign busy = (state_q != S_IDLE) || (cnt_q != '0) || st_vld_q;
  assign err  = err_q;

  // Command stage: load on accept, empty once issued to the table or answered locally.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_vld_q <= 1'b0;
      st_op_q  <= 3'b000;
      st_key_q <= '0;
      st_val_q <= '0;
    end else if (cmd_fire) begin
      st_vld_q <= 1'b1;
      st_op_q  <= cmd_opcode;
      st_key_q <= cmd_key;
      st_val_q <= cmd_value;
    end else if (st_adv) begin
      st_vld_q <= 1'b0;
    end
  end

  // Credits span issue until the client takes the response; local tags are counted separately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q     <= '0;
      lcl_cnt_q <= '0;
    end else begin
      case ({st_adv, out_fire})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      case ({lcl_issue, lcl_done})
        2'b10:   lcl_cnt_q <= lcl_cnt_q + CW'(1);
        2'b01:   lcl_cnt_q <= lcl_cnt_q - CW'(1);
        default: lcl_cnt_q <= lcl_cnt_q;
      endcase
    end
  end

  // CLEAR sequencing: drain outstanding tags, issue CLEAR, wait for its response.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:       if (cmd_fire && (cmd_opcode == OP_CLEAR)) state_q <= S_DRAIN;
        S_DRAIN:      if (req_fire) state_q <= S_CLEAR_WAIT;
        S_CLEAR_WAIT: if (clear_done) state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

  // run_q holds cmd_rdy low until the first edge after reset; err latches unmatched responses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      run_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (rsp_vld && rsp_drop) err_q <= 1'b1;
    end
  end

`ifdef H_INITIATOR_STATS_EN
  // Saturating counters; a CLEAR response wipes them.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_hit   <= '0;
      stat_miss  <= '0;
      stat_issue <= '0;
    end else if (clear_done) begin
      stat_hit   <= '0;
      stat_miss  <= '0;
      stat_issue <= '0;
    end else begin
      if (req_fire && (stat_issue != 32'hFFFF_FFFF)) stat_issue <= stat_issue + 32'd1;
      if (out_fire && (out_opcode == OP_FIND)) begin
        if ((out_status == ST_SUCCESS) && (stat_hit != 32'hFFFF_FFFF))
          stat_hit <= stat_hit + 32'd1;
        else if ((out_status == ST_NOTFOUND) && (stat_miss != 32'hFFFF_FFFF))
          stat_miss <= stat_miss + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_h_initiator.sv
// Testbench for h_initiator: scoreboard of expected requests and client responses,
// plus a scripted hash-table responder that replies in issue order on demand.
module tb_h_initiator;
  localparam int K_W = cfg_pkg::K_W;
  localparam int V_W = cfg_pkg::V_W;
  localparam logic [2:0] OP_INS  = 3'b000;
  localparam logic [2:0] OP_FIND = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b111;
  localparam logic [2:0] OP_BAD  = 3'b010;
  localparam logic [2:0] ST_OK   = 3'b000;
  localparam logic [2:0] ST_NF   = 3'b111;

  typedef struct packed { logic [2:0] op; logic [K_W-1:0] key; logic [V_W-1:0] value; } req_exp_t;
  typedef struct packed { logic [2:0] op; logic [2:0] status; logic [V_W-1:0] value; } out_exp_t;
  typedef struct packed { logic [2:0] status; logic [V_W-1:0] value; } rsp_plan_t;

  logic           clk, arst_n;
  logic           cmd_vld, cmd_rdy;
  logic [2:0]     cmd_opcode;
  logic [K_W-1:0] cmd_key;
  logic [V_W-1:0] cmd_value;
  logic           req_vld, req_rdy;
  logic [2:0]     req_opcode;
  logic [K_W-1:0] req_key;
  logic [V_W-1:0] req_value;
  logic           rsp_vld;
  logic [2:0]     rsp_status;
  logic [V_W-1:0] rsp_value;
  logic           out_vld, out_rdy;
  logic [2:0]     out_opcode, out_status;
  logic [V_W-1:0] out_value;
  logic           busy, err;
`ifdef H_INITIATOR_STATS_EN
  logic [31:0]    stat_hit, stat_miss, stat_issue;
`endif

  int total = 0;
  int bad   = 0;
  int n_req = 0;
  int n_out = 0;
  int base;
  int base_out;

  req_exp_t  exp_req_q[$];
  rsp_plan_t plan_q[$];
  rsp_plan_t pend_q[$];
  out_exp_t  exp_out_q[$];
  req_exp_t  m_req;
  out_exp_t  m_out;

  h_initiator dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_opcode(cmd_opcode), .cmd_key(cmd_key), .cmd_value(cmd_value),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_opcode(req_opcode), .req_key(req_key), .req_value(req_value),
    .rsp_vld(rsp_vld), .rsp_status(rsp_status), .rsp_value(rsp_value),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_opcode(out_opcode), .out_status(out_status), .out_value(out_value),
    .busy(busy), .err(err)
`ifdef H_INITIATOR_STATS_EN
    , .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_issue(stat_issue)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Queue the command's expected request, planned table reply and expected client response, then drive it.
  task automatic send_cmd(input logic [2:0] op, input logic [K_W-1:0] k, input logic [V_W-1:0] v,
                          input logic [2:0] st, input logic [V_W-1:0] rv);
    int n;
    out_exp_t  o;
    req_exp_t  r;
    rsp_plan_t p;
    @(posedge clk); #1;
    if (op == OP_INS || op == OP_FIND || op == OP_CLR) begin
      r.op = op; r.key = k; r.value = v; exp_req_q.push_back(r);
      p.status = st; p.value = rv; plan_q.push_back(p);
      o.op = op; o.status = st; o.value = rv;
    end else begin
      o.op = op; o.status = ST_NF; o.value = '0;
    end
    exp_out_q.push_back(o);
    cmd_vld = 1'b1; cmd_opcode = op; cmd_key = k; cmd_value = v;
    n = 0;
    @(negedge clk);
    while (!cmd_rdy && n < 100) begin @(negedge clk); n++; end
    check("cmd_accept", cmd_rdy, 1);
    @(posedge clk); #1;
    cmd_vld = 1'b0; cmd_opcode = 3'b000; cmd_key = '0; cmd_value = '0;
  endtask

  // Table replies to the oldest unanswered request for one cycle.
  task automatic rsp_one();
    rsp_plan_t p;
    @(posedge clk); #1;
    check("rsp_pending", pend_q.size() != 0, 1);
    if (pend_q.size() != 0) begin
      p = pend_q.pop_front();
      rsp_vld = 1'b1; rsp_status = p.status; rsp_value = p.value;
      @(posedge clk); #1;
      rsp_vld = 1'b0; rsp_status = 3'b000; rsp_value = '0;
    end
  endtask

  task automatic wait_req(input int target, input string tag);
    int n;
    n = 0;
    while (n_req < target && n < 50) begin @(negedge clk); n++; end
    check(tag, n_req, target);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_out_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check(tag, exp_out_q.size(), 0);
  endtask

  // Monitor both output handshakes mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (arst_n && req_vld && req_rdy) begin
      n_req++;
      if (exp_req_q.size() == 0) check("req_unexpected", 1, 0);
      else begin
        m_req = exp_req_q.pop_front();
        check("req_op", req_opcode, m_req.op);
        check("req_key", req_key, m_req.key);
        check("req_val", req_value, m_req.value);
        if (plan_q.size() != 0) pend_q.push_back(plan_q.pop_front());
      end
    end
    if (arst_n && out_vld && out_rdy) begin
      n_out++;
      if (exp_out_q.size() == 0) check("out_unexpected", 1, 0);
      else begin
        m_out = exp_out_q.pop_front();
        check("out_op", out_opcode, m_out.op);
        check("out_status", out_status, m_out.status);
        check("out_val", out_value, m_out.value);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0; cmd_vld = 1'b0; cmd_opcode = 3'b000; cmd_key = '0; cmd_value = '0;
    req_rdy = 1'b0; rsp_vld = 1'b0; rsp_status = 3'b000; rsp_value = '0; out_rdy = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_req_vld", req_vld, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_out_value", out_value, 0);
    arst_n = 1'b1;
    @(negedge clk); check("rdy_before_edge", cmd_rdy, 0);
    @(negedge clk); check("rdy_after_edge", cmd_rdy, 1);

    // INSERT, reply three cycles later, response one cycle after rsp_vld
    req_rdy = 1'b1; out_rdy = 1'b1;
    send_cmd(OP_INS, K_W'(5), V_W'(32'hA), ST_OK, V_W'(32'hA));
    wait_req(1, "ins_issue");
    @(posedge clk);
    @(negedge clk); check("ins_out_idle", out_vld, 0);
    rsp_one();
    @(negedge clk);
    check("ins_out_lat", out_vld, 1);
    check("ins_out_val", out_value, 32'hA);
    wait_drain("ins_drain");

    // Five FINDs with no replies: four issued, fifth held by credits
    base = n_req;
    for (int i = 0; i < 5; i++) send_cmd(OP_FIND, K_W'(i + 1), '0, ST_OK, V_W'(32'h100 + i));
    repeat (3) @(negedge clk);
    check("cred_issued4", n_req, base + 4);
    check("cred_req_vld", req_vld, 0);
    check("cred_cmd_rdy", cmd_rdy, 0);
    check("cred_busy", busy, 1);
    rsp_one();
    wait_req(base + 5, "cred_fifth");
    for (int i = 0; i < 4; i++) rsp_one();
    wait_drain("cred_drain");

    // CLEAR behind two outstanding FINDs
    base = n_req;
    send_cmd(OP_FIND, K_W'(7), '0, ST_NF, '0);
    send_cmd(OP_FIND, K_W'(8), '0, ST_OK, V_W'(32'h55));
    wait_req(base + 2, "clr_finds");
    send_cmd(OP_CLR, '0, '0, ST_OK, '0);
    @(negedge clk); check("clr_rdy_drain", cmd_rdy, 0);
    repeat (2) @(negedge clk); check("clr_held", n_req, base + 2);
    rsp_one();
    repeat (3) @(negedge clk);
    check("clr_held2", n_req, base + 2);
    check("clr_rdy_drain2", cmd_rdy, 0);
    rsp_one();
    wait_req(base + 3, "clr_issue");
    @(negedge clk); check("clr_rdy_wait", cmd_rdy, 0);
    rsp_one();
    @(negedge clk); check("clr_rdy_back", cmd_rdy, 1);
    wait_drain("clr_drain");

    // Four replies buffered while the client stalls
    @(posedge clk); #1 out_rdy = 1'b0;
    base = n_req; base_out = n_out;
    for (int i = 0; i < 4; i++)
      send_cmd(OP_FIND, K_W'(16 + i), '0, (i % 2 == 0) ? ST_OK : ST_NF, V_W'(32'h200 + i));
    wait_req(base + 4, "stall_issue");
    for (int i = 0; i < 4; i++) rsp_one();
    @(negedge clk);
    check("stall_out_vld", out_vld, 1);
    check("stall_no_pop", n_out, base_out);
    @(posedge clk); #1 out_rdy = 1'b1;
    wait_drain("stall_drain");
    check("stall_count", n_out, base_out + 4);

    // Unknown opcode answered locally, ordered behind an outstanding FIND
    base = n_req;
    send_cmd(OP_FIND, K_W'(9), '0, ST_OK, V_W'(32'h77));
    send_cmd(OP_BAD, K_W'(3), V_W'(32'h99), ST_OK, '0);
    repeat (3) @(negedge clk);
    check("unk_out_held", out_vld, 0);
    check("unk_not_issued", n_req, base + 1);
    rsp_one();
    wait_drain("unk_drain");
    check("unk_not_issued2", n_req, base + 1);

    // Response with nothing in flight
    @(negedge clk); check("err_clear", err, 0);
    @(posedge clk); #1 rsp_vld = 1'b1; rsp_value = V_W'(32'h1234);
    @(posedge clk); #1 rsp_vld = 1'b0; rsp_value = '0;
    @(negedge clk);
    check("err_set", err, 1);
    check("err_no_out", out_vld, 0);
    repeat (5) @(negedge clk); check("err_sticky", err, 1);

    // Reset mid-operation, then a late response
    base = n_req;
    send_cmd(OP_FIND, K_W'(10), '0, ST_OK, V_W'(32'h5));
    wait_req(base + 1, "mid_issue");
    @(posedge clk); #1 arst_n = 1'b0;
    #1;
    check("mid_req_vld", req_vld, 0);
    check("mid_cmd_rdy", cmd_rdy, 0);
    check("mid_busy", busy, 0);
    check("mid_err", err, 0);
    check("mid_out_vld", out_vld, 0);
    check("mid_req_key", req_key, 0);
    exp_req_q.delete(); plan_q.delete(); pend_q.delete(); exp_out_q.delete();
    @(posedge clk); #1 arst_n = 1'b1;
    @(negedge clk); @(negedge clk); check("mid_rdy_back", cmd_rdy, 1);
    @(posedge clk); #1 rsp_vld = 1'b1;
    @(posedge clk); #1 rsp_vld = 1'b0;
    @(negedge clk);
    check("late_err", err, 1);
    check("late_no_out", out_vld, 0);

    // FIND hit, miss, hit
    base = n_req;
    send_cmd(OP_FIND, K_W'(1), '0, ST_OK, V_W'(32'h11));
    send_cmd(OP_FIND, K_W'(2), '0, ST_NF, '0);
    send_cmd(OP_FIND, K_W'(3), '0, ST_OK, V_W'(32'h33));
    wait_req(base + 3, "stat_issue3");
    for (int i = 0; i < 3; i++) rsp_one();
    wait_drain("stat_drain");
    @(negedge clk);
`ifdef H_INITIATOR_STATS_EN
    check("stat_hit", stat_hit, 2);
    check("stat_miss", stat_miss, 1);
    check("stat_issue", stat_issue, 3);
`endif
    check("err_persist", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/h_initiator.md
H_INITIATOR -- requirements
Module: h_initiator

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, max hash-table requests in flight (power of 2, 2..16).
REQ-002 Parameter K_W, default cfg_pkg::K_W, key width; V_W, default cfg_pkg::V_W, value width.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 arst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_vld/cmd_rdy  in/out  1/1  client command handshake; cmd_opcode in 3, cmd_key in K_W, cmd_value in V_W.
REQ-006 req_vld/req_rdy  out/in  1/1  hash-table request handshake; req_opcode out 3, req_key out K_W, req_value out V_W.
REQ-007 rsp_vld  in  1  hash-table response, no backpressure; rsp_status in 3, rsp_value in V_W.
REQ-008 out_vld/out_rdy  out/in  1/1  client response handshake; out_opcode out 3, out_status out 3, out_value out V_W.
REQ-009 busy  out  1  state != IDLE or any request in flight; err  out  1  sticky protocol error.

Function
REQ-010 Encodings: OPCODE_INSERT 3'b000, OPCODE_FIND 3'b100, OPCODE_CLEAR 3'b111; STATUS_SUCCESS 3'b000, STATUS_NOTFOUND 3'b111.
REQ-011 Transfer occurs when vld&&rdy on a rising edge; vld and payload held stable until transfer.
REQ-012 Command path is a single registered stage: req_* registered from cmd_*; cmd_rdy = stage empty or (req_vld && req_rdy), gated by REQ-014/016.
REQ-013 Credit counter cnt (0..MAX_OUTSTANDING) increments on req transfer, decrements when a response pops from the response FIFO; both in same cycle leave cnt unchanged.
REQ-014 req_vld deasserts while cnt == MAX_OUTSTANDING; pending request held.
REQ-015 Each issued opcode pushed to in-flight tag FIFO (depth MAX_OUTSTANDING); each rsp_vld pops it and pushes {opcode, rsp_status, rsp_value} to response FIFO (depth MAX_OUTSTANDING).
REQ-016 FSM states IDLE, DRAIN, CLEAR_WAIT; CLEAR accepted only in IDLE.
REQ-017 IDLE: CLEAR accepted at cmd -> DRAIN; cmd_rdy low in DRAIN and CLEAR_WAIT.
REQ-018 DRAIN: CLEAR withheld from req until tag FIFO empty, then issued -> CLEAR_WAIT.
REQ-019 CLEAR_WAIT: on response carrying OPCODE_CLEAR -> IDLE, cmd_rdy may assert next cycle.
REQ-020 out_* driven from response FIFO head; out_vld = FIFO non-empty; zero-cycle pass-through not required, latency rsp_vld -> out_vld is 1 cycle.
REQ-021 Responses returned to client strictly in issue order.
REQ-022 rsp_vld with empty tag FIFO: response dropped, err set, held until reset.
REQ-023 Unknown cmd_opcode: accepted, not issued, response pushed locally with status STATUS_NOTFOUND, value 0, in order behind outstanding responses (takes a credit).
REQ-024 Pointers wrap modulo MAX_OUTSTANDING; full/empty distinguished by extra pointer bit.

Reset
REQ-025 On arst_n low: FSM IDLE, cnt 0, FIFOs empty, req_vld 0, out_vld 0, cmd_rdy 0, busy 0, err 0, payload outputs 0.
REQ-026 cmd_rdy asserts first cycle after arst_n deassertion; reset mid-operation discards all in-flight state, late responses then raise err.

Configuration
REQ-027 Macro H_INITIATOR_STATS_EN: when defined, adds outputs stat_hit (32), stat_miss (32), stat_issue (32).
REQ-028 With macro: stat_issue +1 per req transfer; FIND responses popped to client increment stat_hit on SUCCESS, stat_miss on NOTFOUND; counters saturate at 2^32-1, reset 0, cleared on CLEAR response.
REQ-029 Without macro: ports and counters absent; all other behaviour identical.

Verification
REQ-030 INSERT key 0x5 value 0xA, req_rdy=1, rsp SUCCESS after 3 cycles -> out opcode 000, status 000, value 0xA one cycle after rsp_vld.
REQ-031 Five FINDs, req_rdy=1, no responses -> four issued, fifth held, cmd_rdy low; one response -> fifth issues next cycle.
REQ-032 Two FINDs outstanding, then CLEAR -> CLEAR issued only after both responses; cmd_rdy low until CLEAR response, then high.
REQ-033 rsp_vld with nothing in flight -> err=1, no out_vld, err persists until arst_n.
REQ-034 out_rdy=0 while 4 responses arrive -> all buffered, out order matches issue order, no loss.
REQ-035 With H_INITIATOR_STATS_EN: FIND hit, FIND miss, FIND hit -> stat_hit=2, stat_miss=1, stat_issue=3.
